// File: rtl/race_pkg.sv
// Shared types and default tuning constants for the race game controller.
package race_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RACE      = 3'd2,
    FADE      = 3'd3,
    WIN       = 3'd4,
    LOSE      = 3'd5
  } race_state_t;

  localparam int unsigned DEF_FADE_DIV  = 16;
  localparam logic [15:0] DEF_WIN_DIST  = 16'd65;
  localparam logic [15:0] DEF_LOSE_DIST = 16'h7FFF;
  localparam logic [2:0]  SCALE_MAX     = 3'd7;

endpackage

// File: rtl/frame_divider.sv
// Modulo-DIV frame counter with synchronous clear; tc marks the enabled
// frame on which the count wraps back to zero.
module frame_divider #(
  parameter int unsigned DIV = 16
) (
  input  logic frame_clk,
  input  logic Reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_r;

  assign tc = en & (count_r == LAST);

  // Count enabled frames, wrapping on the terminal value.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= tc ? '0 : count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/race_sequencer.sv
// Frame-rate game FSM: start countdown, live race, crash fade and
// win/lose terminal states, all outputs registered on frame_clk.
module race_sequencer
  import race_pkg::*;
#(
  parameter int unsigned FRAMES_PER_TICK = 60,
  parameter int unsigned COUNT_FROM      = 3,
  parameter int unsigned FADE_DIV        = DEF_FADE_DIV,
  parameter logic [15:0] WIN_DIST        = DEF_WIN_DIST,
  parameter logic [15:0] LOSE_DIST       = DEF_LOSE_DIST
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode_1,
  input  logic [3:0]  PlayerCollide,
  input  logic [15:0] TarDistance,
  input  logic        ai_finished,
  output race_state_t state,
  output logic        race_active,
  output logic [1:0]  Countdown,
  output logic [2:0]  Scale,
  output logic        GameWin,
  output logic        GameLose
);

  localparam logic [1:0] CD_START = 2'(COUNT_FROM);

  logic        key_now_s, key_edge_s, key_prev_r, armed_r;
  logic        lose_s, win_s, hit_s;
  logic        tick_tc_s, fade_tc_s;
  race_state_t state_nxt_s;
  logic [1:0]  cd_nxt_s;
  logic [2:0]  scale_nxt_s;

  assign key_now_s = (keycode_1 != 8'd0);
  // armed_r blocks a start from a key that was already down when reset released
  assign key_edge_s = armed_r & key_now_s & ~key_prev_r;
  assign lose_s = (TarDistance >= LOSE_DIST) | ai_finished;
  assign win_s  = (TarDistance <= WIN_DIST);
  assign hit_s  = |PlayerCollide;

  frame_divider #(.DIV(FRAMES_PER_TICK)) u_tick (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .clr       (state != COUNTDOWN),
    .en        (state == COUNTDOWN),
    .tc        (tick_tc_s)
  );

  frame_divider #(.DIV(FADE_DIV)) u_fade (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .clr       (state != FADE),
    .en        (state == FADE),
    .tc        (fade_tc_s)
  );

  // Key history for rising-edge detection.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_prev_r <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      key_prev_r <= key_now_s;
      armed_r    <= 1'b1;
    end
  end

  // Next-state, countdown digit and fade amount.
  always_comb begin
    state_nxt_s = state;
    cd_nxt_s    = Countdown;
    scale_nxt_s = Scale;
    case (state)
      IDLE: begin
        if (key_edge_s) begin
          state_nxt_s = COUNTDOWN;
          cd_nxt_s    = CD_START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COUNTDOWN: begin
        if (tick_tc_s && (Countdown == 2'd1)) begin
          state_nxt_s = RACE;
          cd_nxt_s    = 2'd0;
        end else if (tick_tc_s) begin
          cd_nxt_s = Countdown - 2'd1;
        end else begin
          cd_nxt_s = Countdown;
        end
      end
      RACE: begin
        if (lose_s) begin
          state_nxt_s = LOSE;
        end else if (win_s) begin
          state_nxt_s = WIN;
        end else if (hit_s) begin
          state_nxt_s = FADE;
          scale_nxt_s = 3'd0;
        end else begin
          state_nxt_s = RACE;
        end
      end
      FADE: begin
        if (lose_s) begin
          state_nxt_s = LOSE;
        end else if (win_s) begin
          state_nxt_s = WIN;
        end else if (!hit_s) begin
          state_nxt_s = RACE;
          scale_nxt_s = 3'd0;
        end else if (fade_tc_s) begin
          scale_nxt_s = Scale + 3'd1;
          state_nxt_s = (Scale == SCALE_MAX - 3'd1) ? LOSE : FADE;
        end else begin
          state_nxt_s = FADE;
        end
      end
      WIN, LOSE: begin
        if (key_edge_s) begin
          state_nxt_s = COUNTDOWN;
          cd_nxt_s    = CD_START;
          scale_nxt_s = 3'd0;
        end else begin
          state_nxt_s = state;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cd_nxt_s    = 2'd0;
        scale_nxt_s = 3'd0;
      end
    endcase
  end

  // State register; flags are decoded from the next state so they track it exactly.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      Countdown   <= 2'd0;
      Scale       <= 3'd0;
      race_active <= 1'b0;
      GameWin     <= 1'b0;
      GameLose    <= 1'b0;
    end else begin
      state       <= state_nxt_s;
      Countdown   <= cd_nxt_s;
      Scale       <= scale_nxt_s;
      race_active <= (state_nxt_s == RACE) | (state_nxt_s == FADE);
      GameWin     <= (state_nxt_s == WIN);
      GameLose    <= (state_nxt_s == LOSE);
    end
  end

endmodule

// File: tb/tb_race_sequencer.sv
// Self-checking bench for race_sequencer against a frame-counting reference model.
module tb_race_sequencer;
  import race_pkg::*;

  localparam int F_TICK = 60;
  localparam int C_FROM = 3;
  localparam int F_DIV  = 16;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  keycode_1;
  logic [3:0]  PlayerCollide;
  logic [15:0] TarDistance;
  logic        ai_finished;
  race_state_t state;
  logic        race_active;
  logic [1:0]  Countdown;
  logic [2:0]  Scale;
  logic        GameWin, GameLose;
  logic [10:0] act_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase plus frames spent in the current phase
  race_state_t m_state;
  int          m_frames;
  int          m_scale;
  bit          m_prev_key, m_armed;

  race_sequencer dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .keycode_1     (keycode_1),
    .PlayerCollide (PlayerCollide),
    .TarDistance   (TarDistance),
    .ai_finished   (ai_finished),
    .state         (state),
    .race_active   (race_active),
    .Countdown     (Countdown),
    .Scale         (Scale),
    .GameWin       (GameWin),
    .GameLose      (GameLose)
  );

  always #5 frame_clk = ~frame_clk;

  assign act_vec = {state, race_active, Countdown, Scale, GameWin, GameLose};

  task automatic model_reset();
    m_state = IDLE; m_frames = 0; m_scale = 0; m_prev_key = 0; m_armed = 0;
  endtask

  task automatic model_step();
    bit ke, lose, win, hit;
    if (Reset_n !== 1'b1) begin
      model_reset();
      return;
    end
    ke   = m_armed && (keycode_1 != 8'd0) && !m_prev_key;
    lose = (TarDistance >= 16'h7FFF) || ai_finished;
    win  = (TarDistance <= 16'd65);
    hit  = (PlayerCollide != 4'd0);
    case (m_state)
      IDLE: if (ke) begin m_state = COUNTDOWN; m_frames = 0; end
      COUNTDOWN: begin
        m_frames++;
        if (m_frames == C_FROM * F_TICK) m_state = RACE;
      end
      RACE: begin
        if (lose) m_state = LOSE;
        else if (win) m_state = WIN;
        else if (hit) begin m_state = FADE; m_frames = 0; m_scale = 0; end
      end
      FADE: begin
        if (lose) m_state = LOSE;
        else if (win) m_state = WIN;
        else if (!hit) begin m_state = RACE; m_scale = 0; end
        else begin
          m_frames++;
          m_scale = m_frames / F_DIV;
          if (m_scale == 7) m_state = LOSE;
        end
      end
      WIN, LOSE: if (ke) begin m_state = COUNTDOWN; m_frames = 0; m_scale = 0; end
      default: ;
    endcase
    m_prev_key = (keycode_1 != 8'd0);
    m_armed = 1;
  endtask

  function automatic logic [10:0] exp_vec();
    logic [1:0] cd;
    cd = (m_state == COUNTDOWN) ? 2'(C_FROM - m_frames / F_TICK) : 2'd0;
    return {m_state, (m_state == RACE) || (m_state == FADE), cd, 3'(m_scale),
            m_state == WIN, m_state == LOSE};
  endfunction

  task automatic step();
    model_step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic clean_inputs();
    keycode_1 = 8'd0; PlayerCollide = 4'd0; TarDistance = 16'd1000; ai_finished = 1'b0;
  endtask

  task automatic press_key();
    keycode_1 = 8'd0;  step();
    keycode_1 = 8'h2C; step();
    keycode_1 = 8'd0;
  endtask

  task automatic go_race();
    clean_inputs();
    press_key();
    repeat (C_FROM * F_TICK) step();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    clean_inputs();
    keycode_1 = 8'h2C;
    model_reset();
    repeat (3) @(posedge frame_clk);
    #1;
    n_tests++;
    if (act_vec !== 11'd0) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", act_vec, 11'd0);
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (state !== IDLE || act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL key_held_after_reset: got %h want %h", act_vec, exp_vec());
      end
    end
    keycode_1 = 8'd0;  step();
    keycode_1 = 8'h2C; step();
    n_tests++;
    if (state !== COUNTDOWN || Countdown !== 2'd3 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL start_edge: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_countdown();
    for (int i = 1; i <= C_FROM * F_TICK; i++) begin
      if (i >= C_FROM * F_TICK - 1) clean_inputs();
      else begin
        keycode_1 = 8'($urandom_range(0, 255));
        PlayerCollide = 4'($urandom_range(0, 15));
        TarDistance = 16'($urandom);
        ai_finished = 1'($urandom_range(0, 1));
      end
      step();
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL countdown_frame%0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (i == C_FROM * F_TICK - 1) begin
        n_tests++;
        if (state !== COUNTDOWN || Countdown !== 2'd1) begin
          n_fail++; $display("FAIL countdown_last: got %h want state 1 digit 1", act_vec);
        end
      end
    end
    n_tests++;
    if (state !== RACE || race_active !== 1'b1 || Countdown !== 2'd0) begin
      n_fail++; $display("FAIL race_start: got %h want RACE active", act_vec);
    end
  endtask

  task automatic test_fade();
    PlayerCollide = 4'b0001;
    step();
    for (int j = 1; j <= 7 * F_DIV; j++) begin
      step();
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL fade_frame%0d: got %h want %h", j, act_vec, exp_vec());
      end
      if (j == F_DIV) begin
        n_tests++;
        if (state !== FADE || Scale !== 3'd1) begin
          n_fail++; $display("FAIL fade_scale1: got scale %0d want 1", Scale);
        end
      end
    end
    n_tests++;
    if (state !== LOSE || Scale !== 3'd7 || GameLose !== 1'b1 || race_active !== 1'b0) begin
      n_fail++; $display("FAIL fade_lose: got %h want LOSE scale 7", act_vec);
    end
    go_race();
    PlayerCollide = 4'b0001;
    repeat (1 + 3 * F_DIV) step();
    n_tests++;
    if (Scale !== 3'd3 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL fade_scale3: got %h want %h", act_vec, exp_vec());
    end
    PlayerCollide = 4'd0;
    step();
    n_tests++;
    if (state !== RACE || Scale !== 3'd0 || race_active !== 1'b1) begin
      n_fail++; $display("FAIL fade_release: got %h want RACE scale 0", act_vec);
    end
  endtask

  task automatic test_win();
    TarDistance = 16'd66;
    repeat (3) step();
    n_tests++;
    if (state !== RACE || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL dist66_stays: got %h want %h", act_vec, exp_vec());
    end
    TarDistance = 16'd65;
    step();
    n_tests++;
    if (state !== WIN || GameWin !== 1'b1 || race_active !== 1'b0 || GameLose !== 1'b0) begin
      n_fail++; $display("FAIL dist65_win: got %h want WIN", act_vec);
    end
  endtask

  task automatic test_restart_and_reset();
    go_race();
    PlayerCollide = 4'b0100;
    repeat (1 + 2 * F_DIV) step();
    TarDistance = 16'd3;
    step();
    n_tests++;
    if (state !== WIN || Scale !== 3'd2 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL win_holds_scale: got %h want %h", act_vec, exp_vec());
    end
    clean_inputs();
    press_key();
    n_tests++;
    if (state !== COUNTDOWN || GameWin !== 1'b0 || Scale !== 3'd0 || Countdown !== 2'd3) begin
      n_fail++; $display("FAIL win_restart: got %h want COUNTDOWN clear", act_vec);
    end
    repeat (30) step();
    #1 Reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (act_vec !== 11'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", act_vec, 11'd0);
    end
    step();
    Reset_n = 1'b1;
    step();
    n_tests++;
    if (act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL post_reset_idle: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_lose_priority();
    go_race();
    TarDistance = 16'h7FFF; ai_finished = 1'b1; PlayerCollide = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if (state !== LOSE || GameWin !== 1'b0 || GameLose !== 1'b1) begin
        n_fail++; $display("FAIL lose_priority%0d: got %h want LOSE", k, act_vec);
      end
    end
    go_race();
    TarDistance = 16'd10; ai_finished = 1'b1;
    step();
    n_tests++;
    if (state !== LOSE || GameWin !== 1'b0) begin
      n_fail++; $display("FAIL win_vs_ai: got %h want LOSE", act_vec);
    end
  endtask

  task automatic test_random();
    bit coll_on = 0;
    int r;
    go_race();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) TarDistance = 16'($urandom_range(32'h7FFF, 32'hFFFF));
      else if (r < 3) TarDistance = 16'($urandom_range(0, 65));
      else TarDistance = 16'($urandom_range(66, 32'h7FFE));
      if ($urandom_range(0, 29) == 0) coll_on = !coll_on;
      PlayerCollide = coll_on ? 4'($urandom_range(1, 15)) : 4'd0;
      ai_finished = ($urandom_range(0, 799) == 0);
      keycode_1 = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      step();
      n_tests++;
      if (act_vec !== exp_vec() || (GameWin && GameLose)) begin
        n_fail++; $display("FAIL random%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_fade();
    go_race();
    test_win();
    test_restart_and_reset();
    test_lose_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/race_sequencer.md
# race_sequencer

Frame-rate game controller that sequences the race datapath: start countdown, live race, crash-fade and win/lose terminal states. Sits beside the color mapper and consumes player collision flags, target distance and key input. It drives the race-enable to player/AI logic, the fade shift amount applied to background/obstacle color, and the win/lose flags used by the final color mux. It replaces the ad-hoc GameStart/GameWin/GameLose and Scale registers with one FSM.

## Interface
- FRAMES_PER_TICK, 60: frames per countdown step (1 s at 60 Hz)
- COUNT_FROM, 3: countdown start value (1..3)
- FADE_DIV, 16: frames per fade step while colliding
- WIN_DIST, 16'd65: TarDistance at or below which the player wins
- LOSE_DIST, 16'h7FFF: TarDistance at or above which the player loses
- frame_clk  in  1  sole clock, one rising edge per video frame
- Reset_n  in  1  asynchronous, active-low reset
- keycode_1  in  8  start/restart key; nonzero = pressed
- PlayerCollide  in  4  per-side player collision flags
- TarDistance  in  16  unsigned distance to finish line
- ai_finished  in  1  AI has reached the finish line
- state  out  3  current FSM state (package enum)
- race_active  out  1  enables ground/player/AI motion
- Countdown  out  2  digit to display during COUNTDOWN, else 0
- Scale  out  3  color right-shift amount (fade)
- GameWin  out  1  win flag
- GameLose  out  1  lose flag

## Operation
- States: IDLE, COUNTDOWN, RACE, FADE, WIN, LOSE.
- key_edge = (keycode_1 != 0) this frame and was 0 the previous frame (one registered key_prev bit).
- IDLE: outputs quiescent; key_edge -> COUNTDOWN, Countdown = COUNT_FROM, tick counter = 0.
- COUNTDOWN: tick counter increments each frame; at FRAMES_PER_TICK-1 it clears and Countdown decrements; when Countdown would go from 1 to 0 -> RACE. key_edge ignored.
- RACE: race_active = 1. Evaluated in priority order each frame: lose condition (TarDistance >= LOSE_DIST or ai_finished) -> LOSE; win (TarDistance <= WIN_DIST) -> WIN; any PlayerCollide bit -> FADE, fade counter = 0.
- FADE: race_active = 1. Fade counter increments each frame; at FADE_DIV-1 it clears and Scale increments. No collision bit set -> Scale = 0, back to RACE same edge. Scale reaching 7 -> LOSE. Lose/win checks of RACE also apply, lose first.
- WIN / LOSE: race_active = 0, Scale held (LOSE keeps final 7 if fade-caused). key_edge -> COUNTDOWN, Scale = 0, flags cleared.
- GameWin = (state == WIN); GameLose = (state == LOSE); both registered, never high together.
- Counters saturate-free: tick counter width ceil(log2(FRAMES_PER_TICK)), fade counter ceil(log2(FADE_DIV)); all compares unsigned.

## Timing
- All state and outputs registered on frame_clk rising edge; response to any input visible one frame later.
- Reset (Reset_n low, async): state = IDLE, race_active = 0, Countdown = 0, Scale = 0, GameWin = 0, GameLose = 0, key_prev = 0, counters = 0. Reset mid-race aborts immediately; no completion.
- Countdown length exactly COUNT_FROM * FRAMES_PER_TICK frames from the key_edge frame to first RACE frame.
- Fade: with continuous collision, Scale reaches 7 after 7*FADE_DIV frames in FADE; LOSE entered on the edge Scale becomes 7.
- Simultaneous win and lose conditions: LOSE wins. Key held through reset: no start until released and pressed again.

## Structure
- Package race_pkg: state enum (race_state_t), default constants WIN_DIST/LOSE_DIST/FADE_DIV.
- Sub-module frame_divider (parameterised modulo counter with clear and terminal pulse), instanced twice (countdown tick, fade step).

## Test plan
- Reset with keycode_1 = 8'h2C held -> state IDLE, all outputs 0; no COUNTDOWN until key released then pressed.
- key_edge in IDLE, defaults -> Countdown 3,2,1 each for 60 frames, RACE and race_active = 1 on frame 181.
- RACE, PlayerCollide = 4'b0001 continuous -> Scale 1 after 16 frames in FADE, LOSE with Scale = 7 after 112 frames; release at Scale = 3 -> Scale 0, RACE next frame.
- RACE, TarDistance = 65 -> WIN next frame, race_active 0; TarDistance = 66 -> stays RACE.
- RACE, TarDistance = 16'h7FFF with ai_finished = 1 and collision -> LOSE, GameWin never asserted.
- WIN, key_edge -> COUNTDOWN with GameWin = 0, Scale = 0; assert Reset_n low mid-countdown -> IDLE asynchronously.
